// File: rtl/ecc_pkg.sv
// ecc_pkg: shared state encodings, point-op codes and default widths for the ECC blocks.
package ecc_pkg;
    localparam int N_DEFAULT = 231;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_DBL = 1'b1;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SCAN = 3'd1,
        NEXT = 3'd2,
        DBL  = 3'd3,
        WDBL = 3'd4,
        CHK  = 3'd5,
        WADD = 3'd6,
        FIN  = 3'd7
    } state_t;
endpackage

// File: rtl/ec_scalar_mult_ctrl.sv
// ec_scalar_mult_ctrl: left-to-right double-and-add sequencer for Q = k*P driving an external point add/double unit.
module ec_scalar_mult_ctrl
    import ecc_pkg::*;
#(
    parameter int N   = N_DEFAULT,
    parameter int K_W = 231,
    parameter int IW  = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [K_W-1:0] k,
    input  logic [N-1:0]   px,
    input  logic [N-1:0]   py,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   qx,
    output logic [N-1:0]   qy,
    output logic           q_inf,
    output logic           op_start,
    output logic           op_dbl,
    output logic [N-1:0]   op_ax,
    output logic [N-1:0]   op_ay,
    output logic [N-1:0]   op_bx,
    output logic [N-1:0]   op_by,
    input  logic           op_done,
    input  logic [N-1:0]   op_rx,
    input  logic [N-1:0]   op_ry,
    input  logic           op_rinf
);
    state_t         state;
    logic [K_W-1:0] kr;
    logic [N-1:0]   pxr, pyr, rx, ry;
    logic           r_inf;
    logic [IW-1:0]  idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            op_start <= 1'b0;
            op_dbl   <= 1'b0;
            q_inf    <= 1'b0;
            qx       <= '0;
            qy       <= '0;
            op_ax    <= '0;
            op_ay    <= '0;
            op_bx    <= '0;
            op_by    <= '0;
            kr       <= '0;
            pxr      <= '0;
            pyr      <= '0;
            rx       <= '0;
            ry       <= '0;
            r_inf    <= 1'b0;
            idx      <= '0;
        end else begin
            done     <= 1'b0;
            op_start <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    kr    <= k;
                    pxr   <= px;
                    pyr   <= py;
                    idx   <= IW'(K_W - 1);
                    busy  <= 1'b1;
                    state <= SCAN;
                end
                // Skip leading zeros; the MSB seeds R = P so no op ever sees P+P.
                SCAN: if (kr[idx]) begin
                    rx    <= pxr;
                    ry    <= pyr;
                    r_inf <= 1'b0;
                    state <= NEXT;
                end else if (idx == '0) begin
                    r_inf <= 1'b1;
                    state <= FIN;
                end else begin
                    idx <= idx - 1'b1;
                end
                NEXT: if (idx == '0) begin
                    state <= FIN;
                end else begin
                    idx   <= idx - 1'b1;
                    state <= DBL;
                end
                DBL: if (r_inf) begin
                    state <= CHK;
                end else begin
                    op_start <= 1'b1;
                    op_dbl   <= OP_DBL;
                    op_ax    <= rx;
                    op_ay    <= ry;
                    op_bx    <= pxr;
                    op_by    <= pyr;
                    state    <= WDBL;
                end
                WDBL: if (op_done) begin
                    rx    <= op_rx;
                    ry    <= op_ry;
                    r_inf <= op_rinf;
                    state <= CHK;
                end
                CHK: if (!kr[idx]) begin
                    state <= NEXT;
                end else if (r_inf) begin
                    rx    <= pxr;
                    ry    <= pyr;
                    r_inf <= 1'b0;
                    state <= NEXT;
                end else begin
                    op_start <= 1'b1;
                    op_dbl   <= OP_ADD;
                    op_ax    <= rx;
                    op_ay    <= ry;
                    op_bx    <= pxr;
                    op_by    <= pyr;
                    state    <= WADD;
                end
                WADD: if (op_done) begin
                    rx    <= op_rx;
                    ry    <= op_ry;
                    r_inf <= op_rinf;
                    state <= NEXT;
                end
                FIN: begin
                    qx    <= r_inf ? '0 : rx;
                    qy    <= r_inf ? '0 : ry;
                    q_inf <= r_inf;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ec_scalar_mult_ctrl.sv
// tb_ec_scalar_mult_ctrl: scoreboard bench with a behavioural point unit on y^2 = x^3+2x+2 mod 17, P = (5,1).
module tb_ec_scalar_mult_ctrl;
    import ecc_pkg::*;

    localparam int N   = 231;
    localparam int K_W = 231;
    localparam int IW  = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [K_W-1:0] k = '0;
    logic [N-1:0]   px = '0, py = '0;
    logic           busy, done, q_inf, op_start, op_dbl;
    logic [N-1:0]   qx, qy, op_ax, op_ay, op_bx, op_by;
    logic           op_done;
    logic           pu_done = 1'b0, spur_done = 1'b0;
    logic [N-1:0]   op_rx = '0, op_ry = '0;
    logic           op_rinf = 1'b0;

    assign op_done = pu_done | spur_done;

    ec_scalar_mult_ctrl #(.N(N), .K_W(K_W), .IW(IW)) dut (
        .clk(clk), .reset(reset), .start(start), .k(k), .px(px), .py(py),
        .busy(busy), .done(done), .qx(qx), .qy(qy), .q_inf(q_inf),
        .op_start(op_start), .op_dbl(op_dbl),
        .op_ax(op_ax), .op_ay(op_ay), .op_bx(op_bx), .op_by(op_by),
        .op_done(op_done), .op_rx(op_rx), .op_ry(op_ry), .op_rinf(op_rinf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] qx;
        logic [N-1:0] qy;
        logic         qinf;
        string        ops;
    } exp_t;

    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    string ops_seen = "";
    bit    pu_busy = 1'b0;
    int    force_lat = 0;
    bit    spur_en = 1'b0;
    int    spur_hits = 0;

    function automatic int md(input int a);
        return ((a % 17) + 17) % 17;
    endfunction

    function automatic int inv(input int a);
        int r = 1;
        for (int i = 0; i < 15; i++) r = md(r * a);
        return r;
    endfunction

    task automatic ec_dbl_m(input int x, input int y, output int rx, output int ry, output bit inf);
        int l;
        inf = (y == 0);
        rx = 0;
        ry = 0;
        if (!inf) begin
            l  = md((3 * x * x + 2) * inv(md(2 * y)));
            rx = md(l * l - 2 * x);
            ry = md(l * (x - rx) - y);
        end
    endtask

    task automatic ec_add_m(input int x1, input int y1, input int x2, input int y2,
                            output int rx, output int ry, output bit inf);
        int l;
        rx = 0;
        ry = 0;
        inf = 1'b0;
        if (x1 == x2) begin
            if (md(y1 + y2) == 0) inf = 1'b1;
            else ec_dbl_m(x1, y1, rx, ry, inf);
        end else begin
            l  = md((y2 - y1) * inv(md(x2 - x1)));
            rx = md(l * l - x1 - x2);
            ry = md(l * (x1 - rx) - y1);
        end
    endtask

    // Behavioural point unit: result returned after a random latency, garbage on the bus when idle.
    initial forever begin
        @(posedge clk);
        #1;
        if (op_start) begin
            int ax, ay, bx, by, rx, ry, lat;
            bit inf, dbl;
            dbl = op_dbl;
            ax = int'(op_ax[7:0]);
            ay = int'(op_ay[7:0]);
            bx = int'(op_bx[7:0]);
            by = int'(op_by[7:0]);
            ops_seen = {ops_seen, dbl ? "D" : "A"};
            if (dbl) ec_dbl_m(ax, ay, rx, ry, inf);
            else ec_add_m(ax, ay, bx, by, rx, ry, inf);
            checks++;
            if (!dbl && ax == bx && ay == by) begin
                errors++;
                $display("FAIL op_p_plus_p actual A=(%0d,%0d) B=(%0d,%0d) required A!=B", ax, ay, bx, by);
            end
            lat = force_lat > 0 ? force_lat : int'($urandom_range(1, 20));
            pu_busy = 1'b1;
            for (int i = 0; i < lat; i++) begin
                @(posedge clk);
                #1;
            end
            if (busy) begin
                checks++;
                if (op_dbl !== dbl || int'(op_ax[7:0]) != ax || int'(op_ay[7:0]) != ay ||
                    int'(op_bx[7:0]) != bx || int'(op_by[7:0]) != by) begin
                    errors++;
                    $display("FAIL op_stable actual dbl=%0d A=(%0d,%0d) required dbl=%0d A=(%0d,%0d)",
                             op_dbl, op_ax[7:0], op_ay[7:0], dbl, ax, ay);
                end
            end
            pu_done = 1'b1;
            op_rx = N'(rx);
            op_ry = N'(ry);
            op_rinf = inf;
            @(posedge clk);
            #1;
            pu_done = 1'b0;
            op_rx = '0;
            op_ry = '0;
            op_rinf = 1'b1;
            pu_busy = 1'b0;
        end
    end

    // Spurious op_done pulses while the controller is not waiting on the point unit.
    initial forever begin
        @(posedge clk);
        #1;
        spur_done = spur_en && (dut.state == DBL || (dut.state == SCAN && $urandom_range(0, 3) == 0));
        if (spur_en && dut.state == DBL) spur_hits++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic run_k(input string name, input logic [K_W-1:0] kv, input int ex, input int ey,
                         input bit einf, input string eops, input bit inject);
        exp_t e;
        bit   got;
        e.qx = N'(ex);
        e.qy = N'(ey);
        e.qinf = einf;
        e.ops = eops;
        sb.push_back(e);
        ops_seen = "";
        px = N'(5);
        py = N'(1);
        k = kv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = ~kv;
        px = N'(7);
        py = N'(7);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start actual %0b required 1", name, busy);
        end
        got = 1'b0;
        for (int cyc = 0; cyc < 20000 && !got; cyc++) begin
            @(posedge clk);
            #1;
            start = inject && cyc == 4;
            if (inject && cyc == 4) k = K_W'(19);
            got = done;
        end
        start = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s done_timeout actual none required done", name);
        end else begin
            checks += 6;
            if (qx !== e.qx) begin
                errors++;
                $display("FAIL %s qx actual %0d required %0d", name, qx, e.qx);
            end
            if (qy !== e.qy) begin
                errors++;
                $display("FAIL %s qy actual %0d required %0d", name, qy, e.qy);
            end
            if (q_inf !== e.qinf) begin
                errors++;
                $display("FAIL %s q_inf actual %0b required %0b", name, q_inf, e.qinf);
            end
            if (ops_seen != e.ops) begin
                errors++;
                $display("FAIL %s ops actual '%s' required '%s'", name, ops_seen, e.ops);
            end
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_at_done actual %0b required 0", name, busy);
            end
            @(posedge clk);
            #1;
            if (done !== 1'b0 || qx !== e.qx || qy !== e.qy || q_inf !== e.qinf) begin
                errors++;
                $display("FAIL %s hold actual done=%0b qx=%0d qy=%0d inf=%0b required done=0 qx=%0d qy=%0d inf=%0b",
                         name, done, qx, qy, q_inf, e.qx, e.qy, e.qinf);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int pass = 0; pass < 2; pass++) begin
            checks += 2;
            if ({busy, done, op_start, q_inf, op_dbl} !== 5'b0) begin
                errors++;
                $display("FAIL reset_flags actual %b required 00000", {busy, done, op_start, q_inf, op_dbl});
            end
            if (|{qx, qy, op_ax, op_ay, op_bx, op_by} !== 1'b0) begin
                errors++;
                $display("FAIL reset_data actual nonzero=%b required 0", |{qx, qy, op_ax, op_ay, op_bx, op_by});
            end
            reset = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_basic();
        run_k("k0", K_W'(0), 0, 0, 1'b1, "", 1'b0);
        run_k("k1", K_W'(1), 5, 1, 1'b0, "", 1'b0);
        run_k("k5", K_W'(5), 9, 16, 1'b0, "DDA", 1'b0);
        run_k("k19", K_W'(19), 0, 0, 1'b1, "DDDADA", 1'b0);
    endtask

    task automatic test_ignored_inputs();
        spur_hits = 0;
        spur_en = 1'b1;
        run_k("k2_noise", K_W'(2), 6, 3, 1'b0, "D", 1'b1);
        spur_en = 1'b0;
        spur_done = 1'b0;
        checks++;
        if (spur_hits == 0) begin
            errors++;
            $display("FAIL spur_in_dbl actual %0d required >0", spur_hits);
        end
    endtask

    task automatic test_reset_mid_op();
        bit hit;
        force_lat = 8;
        ops_seen = "";
        px = N'(5);
        py = N'(1);
        k = K_W'(5);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        hit = 1'b0;
        for (int cyc = 0; cyc < 20000 && !hit; cyc++) begin
            @(posedge clk);
            #1;
            hit = op_start && !op_dbl;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL rst_mid_reach_wadd actual none required add issued");
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks += 2;
        if ({busy, done, op_start, q_inf, op_dbl} !== 5'b0) begin
            errors++;
            $display("FAIL rst_mid_flags actual %b required 00000", {busy, done, op_start, q_inf, op_dbl});
        end
        if (|{qx, qy, op_ax, op_ay, op_bx, op_by} !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_data actual nonzero=%b required 0", |{qx, qy, op_ax, op_ay, op_bx, op_by});
        end
        for (int cyc = 0; cyc < 100 && pu_busy; cyc++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        force_lat = 0;
        checks++;
        if ({busy, done, op_start} !== 3'b0) begin
            errors++;
            $display("FAIL rst_mid_late_done actual %b required 000", {busy, done, op_start});
        end
        run_k("k3_after_rst", K_W'(3), 10, 6, 1'b0, "DA", 1'b0);
    endtask

    task automatic test_back_to_back();
        run_k("b2b_k5", K_W'(5), 9, 16, 1'b0, "DDA", 1'b0);
        run_k("b2b_k1", K_W'(1), 5, 1, 1'b0, "", 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignored_inputs();
        test_reset_mid_op();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
